// File: rtl/hdlc_pkg.sv
// rtl/hdlc_pkg.sv - shared types and sizing helpers for the HDLC receive monitor
package hdlc_pkg;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_DISC = 2'd1,
        EV_FLAG = 2'd2,
        EV_ERR  = 2'd3
    } hdlc_ev_e;

    localparam int HDLC_DEF_RUN_LEN = 5;
    localparam int HDLC_DEF_CNT_W   = 16;

    // Run counter must hold 0..RUN_LEN+2 inclusive.
    function automatic int hdlc_run_w(input int run_len);
        return $clog2(run_len + 3);
    endfunction

    function automatic int hdlc_err_val(input int run_len);
        return run_len + 2;
    endfunction

endpackage

// File: rtl/hdlc_sat_counter.sv
// rtl/hdlc_sat_counter.sv - saturating event counter with clear-over-increment priority
module hdlc_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hdlc_rx_monitor.sv
// rtl/hdlc_rx_monitor.sv - HDLC receive bit-stream monitor: ones-run tracking,
// stuffed-zero / flag / abort detection, frame status and event counters
module hdlc_rx_monitor
    import hdlc_pkg::*;
#(
    parameter int RUN_LEN = HDLC_DEF_RUN_LEN,
    parameter int CNT_W   = HDLC_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    input  logic             clr_cnt,
    output logic             disc,
    output logic             flag,
    output logic             err,
    output logic             in_frame,
    output logic [CNT_W-1:0] disc_cnt,
    output logic [CNT_W-1:0] flag_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int RW = hdlc_run_w(RUN_LEN);
    localparam logic [RW-1:0] DISC_R = RW'(RUN_LEN);
    localparam logic [RW-1:0] FLAG_R = RW'(RUN_LEN + 1);
    localparam logic [RW-1:0] ERR_R  = RW'(hdlc_err_val(RUN_LEN));

    logic [RW-1:0] run;
    logic [RW-1:0] run_nxt;
    hdlc_ev_e      ev;
    logic          err_entry;

    always_comb begin
        run_nxt   = run;
        ev        = EV_NONE;
        err_entry = 1'b0;
        if (in_valid) begin
            if (in) begin
                run_nxt = (run == ERR_R) ? ERR_R : run + 1'b1;
                if (run_nxt == ERR_R) begin
                    ev        = EV_ERR;
                    err_entry = (run == FLAG_R);
                end
            end else begin
                // Any 0 ends the run; a 0 in ERR just returns to idle.
                run_nxt = '0;
                if (run == DISC_R) begin
                    ev = EV_DISC;
                end else if (run == FLAG_R) begin
                    ev = EV_FLAG;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run      <= '0;
            disc     <= 1'b0;
            flag     <= 1'b0;
            err      <= 1'b0;
            in_frame <= 1'b0;
        end else begin
            run  <= run_nxt;
            disc <= (ev == EV_DISC);
            flag <= (ev == EV_FLAG);
            err  <= (ev == EV_ERR);
            // A flag both closes and opens a frame, so it only ever sets.
            if (ev == EV_FLAG) begin
                in_frame <= 1'b1;
            end else if (err_entry) begin
                in_frame <= 1'b0;
            end
        end
    end

    hdlc_sat_counter #(.W(CNT_W)) u_disc_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ev == EV_DISC),
        .clr   (clr_cnt),
        .cnt   (disc_cnt)
    );

    hdlc_sat_counter #(.W(CNT_W)) u_flag_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ev == EV_FLAG),
        .clr   (clr_cnt),
        .cnt   (flag_cnt)
    );

    // Counts abort entries, not every err pulse of a long abort line.
    hdlc_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_entry),
        .clr   (clr_cnt),
        .cnt   (err_cnt)
    );

endmodule

// File: tb/tb_hdlc_rx_monitor.sv
// tb/tb_hdlc_rx_monitor.sv - scoreboard bench for hdlc_rx_monitor (RUN_LEN 5 and 2)
module tb_hdlc_rx_monitor;

    localparam int CW = 4;

    typedef struct packed {
        logic        disc;
        logic        flag;
        logic        err;
        logic        frame;
        logic [31:0] dc;
        logic [31:0] fc;
        logic [31:0] ec;
    } exp_t;

    typedef struct {
        int ones;
        bit frame;
        int dc;
        int fc;
        int ec;
    } mst_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_bit = 1'b0;
    logic in_valid = 1'b0;
    logic clr_cnt = 1'b0;

    logic          disc5, flag5, err5, frame5;
    logic [CW-1:0] dc5, fc5, ec5;
    logic          disc2, flag2, err2, frame2;
    logic [CW-1:0] dc2, fc2, ec2;

    int n_cmp = 0;
    int n_fail = 0;

    exp_t q5[$];
    exp_t q2[$];
    mst_t m5 = '{default: 0};
    mst_t m2 = '{default: 0};

    always #5 clk = ~clk;

    hdlc_rx_monitor #(.RUN_LEN(5), .CNT_W(CW)) dut5 (
        .clk(clk), .reset(reset), .in(in_bit), .in_valid(in_valid), .clr_cnt(clr_cnt),
        .disc(disc5), .flag(flag5), .err(err5), .in_frame(frame5),
        .disc_cnt(dc5), .flag_cnt(fc5), .err_cnt(ec5)
    );

    hdlc_rx_monitor #(.RUN_LEN(2), .CNT_W(CW)) dut2 (
        .clk(clk), .reset(reset), .in(in_bit), .in_valid(in_valid), .clr_cnt(clr_cnt),
        .disc(disc2), .flag(flag2), .err(err2), .in_frame(frame2),
        .disc_cnt(dc2), .flag_cnt(fc2), .err_cnt(ec2)
    );

    // Reference: count ones since the last valid 0 without any bound, and
    // classify each valid bit directly from that count.
    function automatic exp_t step(inout mst_t s, input int rl, input bit v, input bit b, input bit c);
        exp_t e;
        int   mx;
        bit   d, f, er, ent;
        mx = (1 << CW) - 1;
        d = 0; f = 0; er = 0; ent = 0;
        if (v) begin
            if (b) begin
                s.ones++;
                er  = (s.ones >= rl + 2);
                ent = (s.ones == rl + 2);
                if (ent) s.frame = 0;
            end else begin
                d = (s.ones == rl);
                f = (s.ones == rl + 1);
                if (f) s.frame = 1;
                s.ones = 0;
            end
        end
        if (c) begin
            s.dc = 0; s.fc = 0; s.ec = 0;
        end else begin
            if (d   && s.dc < mx) s.dc++;
            if (f   && s.fc < mx) s.fc++;
            if (ent && s.ec < mx) s.ec++;
        end
        e.disc = d; e.flag = f; e.err = er; e.frame = s.frame;
        e.dc = s.dc; e.fc = s.fc; e.ec = s.ec;
        return e;
    endfunction

    task automatic check_ev(input string nm, input exp_t want, input exp_t got);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got disc=%0b flag=%0b err=%0b in_frame=%0b cnt=%0d/%0d/%0d, want disc=%0b flag=%0b err=%0b in_frame=%0b cnt=%0d/%0d/%0d",
                     nm, $time, got.disc, got.flag, got.err, got.frame, got.dc, got.fc, got.ec,
                     want.disc, want.flag, want.err, want.frame, want.dc, want.fc, want.ec);
        end
    endtask

    task automatic check_val(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, got, want);
        end
    endtask

    function automatic exp_t act5();
        exp_t a;
        a.disc = disc5; a.flag = flag5; a.err = err5; a.frame = frame5;
        a.dc = 32'(dc5); a.fc = 32'(fc5); a.ec = 32'(ec5);
        return a;
    endfunction

    function automatic exp_t act2();
        exp_t a;
        a.disc = disc2; a.flag = flag2; a.err = err2; a.frame = frame2;
        a.dc = 32'(dc2); a.fc = 32'(fc2); a.ec = 32'(ec2);
        return a;
    endfunction

    // Monitor: one expectation per driven cycle, checked just after the edge.
    always @(posedge clk) begin
        #1;
        if (q5.size() > 0) check_ev("rl5_out", q5.pop_front(), act5());
        if (q2.size() > 0) check_ev("rl2_out", q2.pop_front(), act2());
    end

    task automatic drive(input bit v, input bit b, input bit c);
        @(negedge clk);
        in_bit = b; in_valid = v; clr_cnt = c;
        q5.push_back(step(m5, 5, v, b, c));
        q2.push_back(step(m2, 2, v, b, c));
    endtask

    task automatic ones(input int n);
        repeat (n) drive(1, 1, 0);
    endtask

    task automatic zero();
        drive(1, 0, 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string nm);
        exp_t z;
        z = '0;
        check_ev({nm, "_rl5"}, z, act5());
        check_ev({nm, "_rl2"}, z, act2());
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 0; clr_cnt = 0;
        #2;
        reset = 1;
        #1;
        check_zero("async_reset");
        m5 = '{default: 0};
        m2 = '{default: 0};
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int r;
        #1;
        check_zero("reset_state");
        @(negedge clk);
        @(negedge clk);
        reset = 0;

        // stuffed zero
        zero(); ones(5); zero();
        settle();
        check_val("disc_cnt_after_disc", 32'(dc5), 1);

        // flag, abort, silent 0
        zero(); ones(6); zero();
        settle();
        check_val("in_frame_after_flag", 32'(frame5), 1);
        ones(7);
        settle();
        check_val("err_cnt_after_abort", 32'(ec5), 1);
        check_val("in_frame_after_abort", 32'(frame5), 0);
        zero();

        // gap in the middle of a flag
        zero(); ones(3);
        repeat (10) drive(0, $urandom_range(0, 1), 0);
        ones(3); zero();

        // saturation, then clear coinciding with a flag
        zero();
        repeat (20) begin ones(6); zero(); end
        settle();
        check_val("flag_cnt_saturated", 32'(fc5), 15);
        ones(6); drive(1, 0, 1);
        settle();
        check_val("flag_cnt_clr_wins", 32'(fc5), 0);

        // reset mid-run, then a stuffed zero evaluated from run=0
        ones(5);
        do_reset();
        zero(); ones(5); zero();
        settle();
        check_val("disc_after_reset", 32'(dc5), 1);
        check_val("flag_after_reset", 32'(fc5), 0);

        // short-run patterns exercised mainly on the RUN_LEN=2 instance
        zero(); ones(2); zero();
        ones(3); zero();
        ones(4); zero();

        // randomized stream biased toward long ones runs
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 99);
            drive(r < 88, ($urandom_range(0, 99) < 72), ($urandom_range(0, 99) < 2));
            if (i == 1200) do_reset();
        end

        repeat (3) @(posedge clk);
        #2;
        check_val("scoreboard_drained_rl5", q5.size(), 0);
        check_val("scoreboard_drained_rl2", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
